// File: rtl/axi_bridge_ip_rx.sv
// Client-IF RX to AXI-Stream packer: gathers IF_W segments into DATA_W beats,
// carries the SOP sideband across the frame, and reports telemetry and errors.
module axi_bridge_ip_rx #(
  parameter int DATA_W  = 256,
  parameter int IF_W    = 64,
  parameter int TUSER_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IF_W-1:0]      cl_rx_data,
  input  logic [IF_W/8-1:0]    cl_rx_keep,
  input  logic [TUSER_W-1:0]   cl_rx_user,
  input  logic                 cl_rx_valid,
  input  logic                 cl_rx_sop,
  input  logic                 cl_rx_eop,
  output logic                 cl_rx_ready,
  output logic [DATA_W-1:0]    m_axis_tdata,
  output logic [DATA_W/8-1:0]  m_axis_tkeep,
  output logic [TUSER_W-1:0]   m_axis_tuser,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  input  logic                 bridge_enable,
  input  logic                 strict_keep_en,
  output logic [31:0]          stat_rx_frames,
  output logic [31:0]          stat_rx_bytes,
  output logic [31:0]          stat_rx_stall_cycles,
  output logic                 ev_err_orphan,
  output logic                 ev_err_sop_midframe,
  output logic                 ev_err_keep_illegal
);

  localparam int SEGS = DATA_W / IF_W;
  localparam int KW   = IF_W / 8;
  localparam int OKW  = DATA_W / 8;
  localparam int IDXW = (SEGS > 1) ? $clog2(SEGS) : 1;

  logic [DATA_W-1:0]  acc_data_q, acc_data_d, out_data_q, out_data_d, beat_data;
  logic [OKW-1:0]     acc_keep_q, acc_keep_d, out_keep_q, out_keep_d, beat_keep;
  logic [TUSER_W-1:0] user_q, user_d, out_user_q, out_user_d, frame_user;
  logic [IDXW-1:0]    seg_idx_q, seg_idx_d;
  logic               in_frame_q, in_frame_d, beat_pending_q, beat_pending_d;
  logic               pend_last_q, pend_last_d, out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [31:0]        frames_q, frames_d, bytes_q, bytes_d, stall_q, stall_d;
  logic               ev_orphan_q, ev_orphan_d, ev_sop_mid_q, ev_sop_mid_d;
  logic               ev_keep_q, ev_keep_d;
  logic               sop_mid, seg_acc, orphan, seg_take, out_free, seg_done;
  logic               keep_bad, hs;
  logic [KW-1:0]      keep_p1;

  assign cl_rx_ready = bridge_enable & ~beat_pending_q & ~(in_frame_q & cl_rx_valid & cl_rx_sop);

  assign m_axis_tdata         = out_data_q;
  assign m_axis_tkeep         = out_keep_q;
  assign m_axis_tuser         = out_user_q;
  assign m_axis_tvalid        = out_valid_q;
  assign m_axis_tlast         = out_last_q;
  assign stat_rx_frames       = frames_q;
  assign stat_rx_bytes        = bytes_q;
  assign stat_rx_stall_cycles = stall_q;
  assign ev_err_orphan        = ev_orphan_q;
  assign ev_err_sop_midframe  = ev_sop_mid_q;
  assign ev_err_keep_illegal  = ev_keep_q;

  // Packing, beat completion, output register load and telemetry next-state.
  always_comb begin
    acc_data_d     = acc_data_q;
    acc_keep_d     = acc_keep_q;
    user_d         = user_q;
    seg_idx_d      = seg_idx_q;
    in_frame_d     = in_frame_q;
    beat_pending_d = beat_pending_q;
    pend_last_d    = pend_last_q;
    out_data_d     = out_data_q;
    out_keep_d     = out_keep_q;
    out_user_d     = out_user_q;
    out_last_d     = out_last_q;
    out_valid_d    = out_valid_q & ~m_axis_tready;
    ev_orphan_d    = 1'b0;
    ev_sop_mid_d   = 1'b0;
    ev_keep_d      = 1'b0;

    // An SOP arriving inside a frame is held off while the open frame is closed.
    sop_mid  = bridge_enable & in_frame_q & cl_rx_valid & cl_rx_sop & ~beat_pending_q;
    seg_acc  = cl_rx_valid & cl_rx_ready;
    orphan   = seg_acc & ~cl_rx_sop & ~in_frame_q;
    seg_take = seg_acc & ~orphan;
    out_free = ~out_valid_q | m_axis_tready;
    seg_done = (seg_idx_q == IDXW'(SEGS - 1)) | cl_rx_eop;
    frame_user = cl_rx_sop ? cl_rx_user : user_q;

    beat_data = acc_data_q;
    beat_keep = acc_keep_q;
    beat_data[seg_idx_q*IF_W +: IF_W] = cl_rx_data;
    beat_keep[seg_idx_q*KW +: KW]     = cl_rx_keep;

    // EOP keep must be a non-empty run of ones from the LSB.
    keep_p1  = cl_rx_keep + KW'(1);
    keep_bad = cl_rx_eop ? ((cl_rx_keep == '0) | ((cl_rx_keep & keep_p1) != '0))
                         : (cl_rx_keep != '1);

    if (beat_pending_q) begin
      if (out_free) begin
        out_data_d     = acc_data_q;
        out_keep_d     = acc_keep_q;
        out_user_d     = user_q;
        out_last_d     = pend_last_q;
        out_valid_d    = 1'b1;
        acc_data_d     = '0;
        acc_keep_d     = '0;
        beat_pending_d = 1'b0;
      end
    end else if (sop_mid) begin
      if (out_free) begin
        out_data_d  = acc_data_q;
        out_keep_d  = acc_keep_q;
        out_user_d  = user_q;
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
        acc_data_d  = '0;
        acc_keep_d  = '0;
      end else begin
        beat_pending_d = 1'b1;
        pend_last_d    = 1'b1;
      end
      seg_idx_d    = '0;
      in_frame_d   = 1'b0;
      ev_sop_mid_d = 1'b1;
    end else if (seg_take) begin
      user_d    = frame_user;
      ev_keep_d = strict_keep_en & keep_bad;
      if (seg_done) begin
        seg_idx_d  = '0;
        in_frame_d = ~cl_rx_eop;
        if (out_free) begin
          out_data_d  = beat_data;
          out_keep_d  = beat_keep;
          out_user_d  = frame_user;
          out_last_d  = cl_rx_eop;
          out_valid_d = 1'b1;
          acc_data_d  = '0;
          acc_keep_d  = '0;
        end else begin
          acc_data_d     = beat_data;
          acc_keep_d     = beat_keep;
          beat_pending_d = 1'b1;
          pend_last_d    = cl_rx_eop;
        end
      end else begin
        acc_data_d = beat_data;
        acc_keep_d = beat_keep;
        seg_idx_d  = seg_idx_q + IDXW'(1);
        in_frame_d = 1'b1;
      end
    end

    if (orphan) ev_orphan_d = 1'b1;

    hs       = out_valid_q & m_axis_tready;
    frames_d = frames_q + 32'(hs & out_last_q);
    bytes_d  = bytes_q + (hs ? 32'($countones(out_keep_q)) : 32'd0);
    stall_d  = stall_q + 32'(out_valid_q & ~m_axis_tready);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_data_q     <= '0;
      acc_keep_q     <= '0;
      user_q         <= '0;
      seg_idx_q      <= '0;
      in_frame_q     <= 1'b0;
      beat_pending_q <= 1'b0;
      pend_last_q    <= 1'b0;
      out_data_q     <= '0;
      out_keep_q     <= '0;
      out_user_q     <= '0;
      out_last_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      frames_q       <= '0;
      bytes_q        <= '0;
      stall_q        <= '0;
      ev_orphan_q    <= 1'b0;
      ev_sop_mid_q   <= 1'b0;
      ev_keep_q      <= 1'b0;
    end else begin
      acc_data_q     <= acc_data_d;
      acc_keep_q     <= acc_keep_d;
      user_q         <= user_d;
      seg_idx_q      <= seg_idx_d;
      in_frame_q     <= in_frame_d;
      beat_pending_q <= beat_pending_d;
      pend_last_q    <= pend_last_d;
      out_data_q     <= out_data_d;
      out_keep_q     <= out_keep_d;
      out_user_q     <= out_user_d;
      out_last_q     <= out_last_d;
      out_valid_q    <= out_valid_d;
      frames_q       <= frames_d;
      bytes_q        <= bytes_d;
      stall_q        <= stall_d;
      ev_orphan_q    <= ev_orphan_d;
      ev_sop_mid_q   <= ev_sop_mid_d;
      ev_keep_q      <= ev_keep_d;
    end
  end

endmodule

// File: tb/tb_axi_bridge_ip_rx.sv
// Directed bench for axi_bridge_ip_rx with default parameters (256/64/16).
module tb_axi_bridge_ip_rx;
  localparam int DATA_W = 256;
  localparam int IF_W = 64;
  localparam int TUSER_W = 16;

  logic clk = 1'b0;
  logic rst_i;
  logic [IF_W-1:0] cl_rx_data;
  logic [IF_W/8-1:0] cl_rx_keep;
  logic [TUSER_W-1:0] cl_rx_user;
  logic cl_rx_valid, cl_rx_sop, cl_rx_eop, cl_rx_ready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [DATA_W/8-1:0] m_axis_tkeep;
  logic [TUSER_W-1:0] m_axis_tuser;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic bridge_enable, strict_keep_en;
  logic [31:0] stat_rx_frames, stat_rx_bytes, stat_rx_stall_cycles;
  logic ev_err_orphan, ev_err_sop_midframe, ev_err_keep_illegal;

  typedef struct {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] keep;
    logic [TUSER_W-1:0]  user;
    logic                last;
  } beat_t;

  beat_t beats[$];
  int vec_cnt = 0;
  int err_cnt = 0;
  int n_orphan = 0, n_sopmid = 0, n_keep = 0;
  int exp_frames = 0, exp_bytes = 0, exp_stall = 0;

  always #5 clk = ~clk;

  axi_bridge_ip_rx #(.DATA_W(DATA_W), .IF_W(IF_W), .TUSER_W(TUSER_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cl_rx_data(cl_rx_data), .cl_rx_keep(cl_rx_keep), .cl_rx_user(cl_rx_user),
    .cl_rx_valid(cl_rx_valid), .cl_rx_sop(cl_rx_sop), .cl_rx_eop(cl_rx_eop),
    .cl_rx_ready(cl_rx_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .bridge_enable(bridge_enable), .strict_keep_en(strict_keep_en),
    .stat_rx_frames(stat_rx_frames), .stat_rx_bytes(stat_rx_bytes),
    .stat_rx_stall_cycles(stat_rx_stall_cycles),
    .ev_err_orphan(ev_err_orphan), .ev_err_sop_midframe(ev_err_sop_midframe),
    .ev_err_keep_illegal(ev_err_keep_illegal)
  );

  // Capture handshakes and event-pulse cycles midway between active edges.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready)
      beats.push_back('{data: m_axis_tdata, keep: m_axis_tkeep, user: m_axis_tuser, last: m_axis_tlast});
    if (ev_err_orphan) n_orphan++;
    if (ev_err_sop_midframe) n_sopmid++;
    if (ev_err_keep_illegal) n_keep++;
  end

  function automatic logic [IF_W-1:0] sv(input int f, input int i);
    return {32'hF000_0000 + 32'(f), 32'hA000_0000 + 32'(i)};
  endfunction

  task automatic send_seg(input logic [IF_W-1:0] d, input logic [7:0] k,
                          input logic [TUSER_W-1:0] u, input logic sop, input logic eop);
    int n;
    n = 0;
    cl_rx_data = d; cl_rx_keep = k; cl_rx_user = u;
    cl_rx_sop = sop; cl_rx_eop = eop; cl_rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cl_rx_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        vec_cnt++; err_cnt++;
        $display("FAIL send_timeout: segment not accepted after %0d cycles (required acceptance)", n);
        break;
      end
    end
    cl_rx_valid = 1'b0; cl_rx_sop = 1'b0; cl_rx_eop = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    vec_cnt++;
    if (stat_rx_frames !== 32'(exp_frames)) begin
      err_cnt++; $display("FAIL %s_frames: got %0d want %0d", tag, stat_rx_frames, exp_frames);
    end
    vec_cnt++;
    if (stat_rx_bytes !== 32'(exp_bytes)) begin
      err_cnt++; $display("FAIL %s_bytes: got %0d want %0d", tag, stat_rx_bytes, exp_bytes);
    end
    vec_cnt++;
    if (stat_rx_stall_cycles !== 32'(exp_stall)) begin
      err_cnt++; $display("FAIL %s_stall: got %0d want %0d", tag, stat_rx_stall_cycles, exp_stall);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [DATA_W-1:0] d,
                            input logic [DATA_W/8-1:0] k, input logic [TUSER_W-1:0] u, input logic l);
    vec_cnt++;
    if (idx >= beats.size()) begin
      err_cnt++; $display("FAIL %s_missing: beat %0d absent, have %0d", tag, idx, beats.size());
      return;
    end
    if (beats[idx].data !== d || beats[idx].keep !== k || beats[idx].user !== u || beats[idx].last !== l) begin
      err_cnt++;
      $display("FAIL %s_beat%0d: got keep=%h user=%h last=%b data=%h want keep=%h user=%h last=%b data=%h",
               tag, idx, beats[idx].keep, beats[idx].user, beats[idx].last, beats[idx].data, k, u, l, d);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; bridge_enable = 1'b0; strict_keep_en = 1'b0; m_axis_tready = 1'b1;
    cl_rx_valid = 1'b0; cl_rx_sop = 1'b0; cl_rx_eop = 1'b0;
    cl_rx_data = '0; cl_rx_keep = '0; cl_rx_user = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if ({m_axis_tvalid, m_axis_tlast, cl_rx_ready, ev_err_orphan, ev_err_sop_midframe, ev_err_keep_illegal} !== 6'b0
        || m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tuser !== '0) begin
      err_cnt++; $display("FAIL reset_outputs: tvalid=%b tlast=%b ready=%b tkeep=%h want all zero",
                          m_axis_tvalid, m_axis_tlast, cl_rx_ready, m_axis_tkeep);
    end
    check_stats("reset");
    @(posedge clk); #1;
    rst_i = 1'b0; bridge_enable = 1'b1;
    beats.delete();
  endtask

  task automatic test_full_frame();
    int base;
    base = beats.size();
    for (int i = 0; i < 8; i++)
      send_seg(sv(1, i), 8'hFF, (i == 0) ? 16'hA5A5 : 16'h0000, i == 0, i == 7);
    repeat (4) @(posedge clk); #1;
    check_beat("full", base + 0, {sv(1,3), sv(1,2), sv(1,1), sv(1,0)}, '1, 16'hA5A5, 1'b0);
    check_beat("full", base + 1, {sv(1,7), sv(1,6), sv(1,5), sv(1,4)}, '1, 16'hA5A5, 1'b1);
    vec_cnt++;
    if (beats.size() != base + 2) begin
      err_cnt++; $display("FAIL full_count: got %0d beats want 2", beats.size() - base);
    end
    exp_frames += 1; exp_bytes += 64;
    check_stats("full");
  endtask

  task automatic test_single_seg();
    int base;
    base = beats.size();
    send_seg(sv(2, 0), 8'h0F, 16'h1234, 1'b1, 1'b1);
    vec_cnt++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tkeep !== 32'h0000_000F || m_axis_tlast !== 1'b1
        || m_axis_tdata !== {192'b0, sv(2, 0)}) begin
      err_cnt++; $display("FAIL single_latency: tvalid=%b tkeep=%h tlast=%b want 1 0000000f 1",
                          m_axis_tvalid, m_axis_tkeep, m_axis_tlast);
    end
    repeat (3) @(posedge clk); #1;
    check_beat("single", base, {192'b0, sv(2, 0)}, 32'h0000_000F, 16'h1234, 1'b1);
    exp_frames += 1; exp_bytes += 4;
    check_stats("single");
  endtask

  task automatic test_backpressure();
    int base;
    base = beats.size();
    fork
      begin
        for (int i = 0; i < 12; i++)
          send_seg(sv(3, i), 8'hFF, (i == 0) ? 16'hBEEF : 16'h0000, i == 0, i == 11);
      end
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!(m_axis_tvalid && m_axis_tready) && k < 200) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        @(negedge clk);
        while (!m_axis_tvalid && k < 400) begin @(negedge clk); k++; end
        vec_cnt++;
        if (k >= 200) begin
          err_cnt++; $display("FAIL bp_wait: tvalid wait expired (%0d) want beat", k);
        end
        repeat (10) @(posedge clk);
        #1;
        vec_cnt++;
        if (cl_rx_ready !== 1'b0) begin
          err_cnt++; $display("FAIL bp_ready: cl_rx_ready=%b want 0 while beat pending", cl_rx_ready);
        end
        m_axis_tready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    check_beat("bp", base + 0, {sv(3,3), sv(3,2), sv(3,1), sv(3,0)}, '1, 16'hBEEF, 1'b0);
    check_beat("bp", base + 1, {sv(3,7), sv(3,6), sv(3,5), sv(3,4)}, '1, 16'hBEEF, 1'b0);
    check_beat("bp", base + 2, {sv(3,11), sv(3,10), sv(3,9), sv(3,8)}, '1, 16'hBEEF, 1'b1);
    exp_frames += 1; exp_bytes += 96; exp_stall += 10;
    check_stats("bp");
  endtask

  task automatic test_orphan();
    int base, o0;
    base = beats.size(); o0 = n_orphan;
    send_seg(sv(4, 0), 8'hFF, 16'h7777, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    vec_cnt++;
    if (n_orphan - o0 != 1) begin
      err_cnt++; $display("FAIL orphan_pulse: got %0d pulse cycles want 1", n_orphan - o0);
    end
    vec_cnt++;
    if (beats.size() != base || m_axis_tvalid !== 1'b0) begin
      err_cnt++; $display("FAIL orphan_drop: got %0d beats tvalid=%b want 0 0", beats.size() - base, m_axis_tvalid);
    end
    check_stats("orphan");
  endtask

  task automatic test_sop_midframe();
    int base, s0;
    base = beats.size(); s0 = n_sopmid;
    send_seg(sv(5, 0), 8'hFF, 16'h1111, 1'b1, 1'b0);
    send_seg(sv(5, 1), 8'hFF, 16'h0000, 1'b0, 1'b0);
    send_seg(sv(6, 0), 8'hFF, 16'h2222, 1'b1, 1'b1);
    repeat (4) @(posedge clk); #1;
    vec_cnt++;
    if (n_sopmid - s0 != 1) begin
      err_cnt++; $display("FAIL sopmid_pulse: got %0d pulse cycles want 1", n_sopmid - s0);
    end
    check_beat("sopmid", base + 0, {128'b0, sv(5,1), sv(5,0)}, 32'h0000_FFFF, 16'h1111, 1'b1);
    check_beat("sopmid", base + 1, {192'b0, sv(6,0)}, 32'h0000_00FF, 16'h2222, 1'b1);
    exp_frames += 2; exp_bytes += 24;
    check_stats("sopmid");
  endtask

  task automatic test_keep_illegal();
    int base, k0;
    base = beats.size(); k0 = n_keep;
    strict_keep_en = 1'b1;
    send_seg(sv(7, 0), 8'h0F, 16'h3333, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;
    vec_cnt++;
    if (n_keep != k0) begin
      err_cnt++; $display("FAIL keep_legal: got %0d pulse cycles want 0", n_keep - k0);
    end
    send_seg(sv(8, 0), 8'hF0, 16'h4444, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;
    vec_cnt++;
    if (n_keep - k0 != 1) begin
      err_cnt++; $display("FAIL keep_illegal_pulse: got %0d pulse cycles want 1", n_keep - k0);
    end
    check_beat("keep", base + 0, {192'b0, sv(7,0)}, 32'h0000_000F, 16'h3333, 1'b1);
    check_beat("keep", base + 1, {192'b0, sv(8,0)}, 32'h0000_00F0, 16'h4444, 1'b1);
    strict_keep_en = 1'b0;
    exp_frames += 2; exp_bytes += 8;
    check_stats("keep");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_single_seg();
    test_backpressure();
    test_orphan();
    test_sop_midframe();
    test_keep_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
